// File: rtl/seg7_scan_ctrl.sv
// ---------------------------------------------------------------------------
// seg7_scan_ctrl
//
// Multiplexed seven-segment display controller for NDIG common-anode digits.
// A host writes character codes into a shadow buffer. On request, the shadow
// buffer is copied to the active buffer at the next frame boundary, so a
// frame never shows a mix of old and new characters. Two effects are applied
// on top of plain scanning:
//   - per-digit blink, which blanks the digit on alternate blink half-periods
//   - global brightness, which is a PWM inside each digit slot
//
// Ports
//   clk            system clock, rising edge
//   reset          synchronous, active-high
//   wr_en          write strobe into the shadow buffer
//   wr_addr        digit index, 0 = leftmost (AN[NDIG-1]); values >= NDIG
//                  are ignored
//   wr_data        5-bit character code
//   commit         one-cycle request to copy shadow -> active at frame start
//   blink_mask     bit i set: digit i blinks
//   bright         on-time within a slot, 0..15 (15 = full duty)
//   AN             anode enables, active-low, one-hot-low while lit
//   CN             segments {g,f,e,d,c,b,a}, active-low
//   commit_pending high from commit acceptance until the copy is done
//   frame_start    one-cycle pulse when the scan wraps back to digit 0
// ---------------------------------------------------------------------------
module seg7_scan_ctrl #(
    parameter  int NDIG         = 4,
    parameter  int PRESC        = 50000,
    parameter  int BLINK_FRAMES = 32,
    localparam int AW           = $clog2(NDIG)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            wr_en,
    input  logic [AW-1:0]   wr_addr,
    input  logic [4:0]      wr_data,
    input  logic            commit,
    input  logic [NDIG-1:0] blink_mask,
    input  logic [3:0]      bright,
    output logic [NDIG-1:0] AN,
    output logic [6:0]      CN,
    output logic            commit_pending,
    output logic            frame_start
);

    localparam int PW = (PRESC > 1) ? $clog2(PRESC) : 1;
    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [4:0] CODE_BLANK = 5'h10;
    localparam logic [6:0] SEG_OFF    = 7'b1111111;

    logic [PW-1:0] pcnt;
    logic [3:0]    sub;
    logic [AW-1:0] dig;
    logic [BW-1:0] bcnt;
    logic          blink_phase;

    logic          tick;
    logic          slot_end;

    logic [4:0]    shadow [NDIG];
    logic [4:0]    active [NDIG];

    logic [4:0]      cur_code;
    logic            cur_blink;
    logic            lit;
    logic [NDIG-1:0] an_next;
    logic [6:0]      cn_next;

    // Character code to active-low segment pattern {g,f,e,d,c,b,a}.
    function automatic logic [6:0] glyph(input logic [4:0] code);
        logic [6:0] seg;
        case (code)
            5'h00:   seg = 7'b1000000;
            5'h01:   seg = 7'b1111001;
            5'h02:   seg = 7'b0100100;
            5'h03:   seg = 7'b0110000;
            5'h04:   seg = 7'b0011001;
            5'h05:   seg = 7'b0010010;
            5'h06:   seg = 7'b0000010;
            5'h07:   seg = 7'b1111000;
            5'h08:   seg = 7'b0000000;
            5'h09:   seg = 7'b0010000;
            5'h0A:   seg = 7'b0001000;
            5'h0B:   seg = 7'b0000011;
            5'h0C:   seg = 7'b1000110;
            5'h0D:   seg = 7'b0100001;
            5'h0E:   seg = 7'b0000110;
            5'h0F:   seg = 7'b0001110;
            5'h11:   seg = 7'b0111111;
            5'h12:   seg = 7'b0001001;
            5'h13:   seg = 7'b0101011;
            5'h14:   seg = 7'b0101111;
            5'h15:   seg = 7'b1000111;
            default: seg = SEG_OFF;
        endcase
        return seg;
    endfunction

    // The scan hierarchy is prescaler -> 16 sub-slots -> digit. A frame ends
    // on the last prescaler cycle of the last sub-slot of the last digit.
    assign tick        = (pcnt == PW'(PRESC - 1));
    assign slot_end    = tick && (sub == 4'hF);
    assign frame_start = slot_end && (dig == AW'(NDIG - 1));

    // Scan counters and the blink half-period counter. blink_phase toggles
    // once every BLINK_FRAMES frames.
    always_ff @(posedge clk) begin
        if (reset) begin
            pcnt        <= '0;
            sub         <= '0;
            dig         <= '0;
            bcnt        <= '0;
            blink_phase <= 1'b0;
        end else begin
            if (tick) begin
                pcnt <= '0;
                sub  <= sub + 4'd1;
            end else begin
                pcnt <= pcnt + PW'(1);
            end
            if (slot_end) begin
                if (dig == AW'(NDIG - 1)) begin
                    dig <= '0;
                end else begin
                    dig <= dig + AW'(1);
                end
            end
            if (frame_start) begin
                if (bcnt == BW'(BLINK_FRAMES - 1)) begin
                    bcnt        <= '0;
                    blink_phase <= ~blink_phase;
                end else begin
                    bcnt <= bcnt + BW'(1);
                end
            end
        end
    end

    // Shadow/active double buffer. The copy uses the shadow contents from
    // before this edge, so a write in the copy cycle lands in shadow only and
    // waits for the next commit. A commit that arrives exactly on a frame
    // start is served at once and never raises commit_pending.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NDIG; i++) begin
                shadow[i] <= CODE_BLANK;
                active[i] <= CODE_BLANK;
            end
            commit_pending <= 1'b0;
        end else begin
            for (int i = 0; i < NDIG; i++) begin
                if (wr_en && (wr_addr == AW'(i))) begin
                    shadow[i] <= wr_data;
                end
            end
            if (frame_start && (commit_pending || commit)) begin
                for (int i = 0; i < NDIG; i++) begin
                    active[i] <= shadow[i];
                end
                commit_pending <= 1'b0;
            end else if (commit) begin
                commit_pending <= 1'b1;
            end
        end
    end

    // Select the current digit's code and blink bit, then decide whether it
    // is lit. The digit is selected by comparison rather than direct indexing
    // so that dig values past NDIG-1 (unreachable) never address outside the
    // arrays when NDIG is not a power of two.
    always_comb begin
        cur_code  = CODE_BLANK;
        cur_blink = 1'b0;
        an_next   = '1;
        for (int i = 0; i < NDIG; i++) begin
            if (dig == AW'(i)) begin
                cur_code  = active[i];
                cur_blink = blink_mask[i];
            end
        end
        lit = (sub <= bright) && !(cur_blink && blink_phase);
        if (lit) begin
            for (int i = 0; i < NDIG; i++) begin
                if (dig == AW'(i)) begin
                    an_next[NDIG-1-i] = 1'b0;
                end
            end
        end
        cn_next = lit ? glyph(cur_code) : SEG_OFF;
    end

    // Registered pin drivers. The display goes dark from the reset edge on.
    always_ff @(posedge clk) begin
        if (reset) begin
            AN <= '1;
            CN <= SEG_OFF;
        end else begin
            AN <= an_next;
            CN <= cn_next;
        end
    end

endmodule
